// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: axis segment encoding
// and the power-on video mode (1920x1080, CEA-861 1080p timing).
package video_timing_pkg;

    // Segment an axis counter is currently in; order follows the raster.
    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    // Power-on mode, horizontal axis (pixels).
    localparam int DEF_HACTIVE = 1920;
    localparam int DEF_HFRONT  = 88;
    localparam int DEF_HSYNC   = 44;
    localparam int DEF_HBACK   = 148;

    // Power-on mode, vertical axis (lines).
    localparam int DEF_VACTIVE = 1080;
    localparam int DEF_VFRONT  = 4;
    localparam int DEF_VSYNC   = 5;
    localparam int DEF_VBACK   = 36;

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing generator bundle: run control, mode configuration and the raster
// outputs. The generator is the master; the pixel path / controller is the slave.
interface video_timing_gen_if #(
    parameter int busWidth = 12
);
    logic                enable;
    logic [busWidth-1:0] hActive;
    logic [busWidth-1:0] hFront;
    logic [busWidth-1:0] hSync;
    logic [busWidth-1:0] hBack;
    logic [busWidth-1:0] vActive;
    logic [busWidth-1:0] vFront;
    logic [busWidth-1:0] vSync;
    logic [busWidth-1:0] vBack;
    logic                hSyncPol;
    logic                vSyncPol;
    logic                cfgUpdate;

    logic                deOut;
    logic                hSyncOut;
    logic                vSyncOut;
    logic [busWidth-1:0] hPos;
    logic [busWidth-1:0] vPos;
    logic                lineStart;
    logic                frameStart;
    logic                cfgPending;

    modport master (
        input  enable, hActive, hFront, hSync, hBack,
               vActive, vFront, vSync, vBack, hSyncPol, vSyncPol, cfgUpdate,
        output deOut, hSyncOut, vSyncOut, hPos, vPos, lineStart, frameStart, cfgPending
    );

    modport slave (
        output enable, hActive, hFront, hSync, hBack,
               vActive, vFront, vSync, vBack, hSyncPol, vSyncPol, cfgUpdate,
        input  deOut, hSyncOut, vSyncOut, hPos, vPos, lineStart, frameStart, cfgPending
    );

endinterface

// File: rtl/timing_axis.sv
// One raster axis: position counter plus a four-segment FSM
// (ACTIVE -> FRONT -> SYNC -> BACK). inActive/inSync describe the position
// that is loaded at the coming edge, so the parent can register them in step
// with pos. wrap flags an advance that returns pos to 0.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int busWidth = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                advance,
    input  logic [busWidth-1:0] actLen,
    input  logic [busWidth-1:0] frontLen,
    input  logic [busWidth-1:0] syncLen,
    input  logic [busWidth-1:0] backLen,
    output logic [busWidth-1:0] pos,
    output logic                inActive,
    output logic                inSync,
    output logic                wrap
);

    localparam int sumWidth = busWidth + 2;

    logic [1:0]          state;
    logic [1:0]          stateNext;
    logic [busWidth-1:0] posNext;
    logic [sumWidth-1:0] endActive;
    logic [sumWidth-1:0] endFront;
    logic [sumWidth-1:0] endSync;
    logic [sumWidth-1:0] total;
    logic [sumWidth-1:0] posInc;

    // A zero-length segment still occupies one position, so no state is ever empty.
    function automatic logic [sumWidth-1:0] atLeastOne(input logic [busWidth-1:0] len);
        return (len == '0) ? sumWidth'(1) : sumWidth'(len);
    endfunction

    // Cumulative segment boundaries, widened so four max-length fields cannot overflow.
    always_comb begin
        endActive = atLeastOne(actLen);
        endFront  = endActive + atLeastOne(frontLen);
        endSync   = endFront + atLeastOne(syncLen);
        total     = endSync + atLeastOne(backLen);
    end

    assign posInc = sumWidth'(pos) + sumWidth'(1);
    assign wrap   = advance && (posInc >= total);

    // Next position and segment; a single step crosses at most one boundary.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        stateNext = state;
        posNext   = pos;
        if (advance) begin
            posNext = wrap ? '0 : pos + busWidth'(1);
            case (state)
                ST_ACTIVE: if (posInc >= endActive) stateNext = ST_FRONT;
                ST_FRONT:  if (posInc >= endFront)  stateNext = ST_SYNC;
                ST_SYNC:   if (posInc >= endSync)   stateNext = ST_BACK;
                default:   ;
            endcase
            if (wrap) begin
                stateNext = ST_ACTIVE;
            end
        end
    end

    assign inActive = (stateNext == ST_ACTIVE);
    assign inSync   = (stateNext == ST_SYNC);

    // Counter and segment registers.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            pos   <= '0;
            state <= ST_ACTIVE;
        end else begin
            pos   <= posNext;
            state <= stateNext;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator top: staging/shadow mode registers, sync polarity
// and registered raster outputs. The vertical axis advances on the horizontal
// wrap; a staged mode is applied only on the edge that enters pixel (0,0).
module video_timing_gen #(
    parameter int busWidth    = 12,
    parameter int DEF_HACTIVE = video_timing_pkg::DEF_HACTIVE,
    parameter int DEF_HFRONT  = video_timing_pkg::DEF_HFRONT,
    parameter int DEF_HSYNC   = video_timing_pkg::DEF_HSYNC,
    parameter int DEF_HBACK   = video_timing_pkg::DEF_HBACK,
    parameter int DEF_VACTIVE = video_timing_pkg::DEF_VACTIVE,
    parameter int DEF_VFRONT  = video_timing_pkg::DEF_VFRONT,
    parameter int DEF_VSYNC   = video_timing_pkg::DEF_VSYNC,
    parameter int DEF_VBACK   = video_timing_pkg::DEF_VBACK
) (
    input logic               clock,
    input logic               reset,
    video_timing_gen_if.master vt
);

    typedef struct packed {
        logic [busWidth-1:0] hActive;
        logic [busWidth-1:0] hFront;
        logic [busWidth-1:0] hSync;
        logic [busWidth-1:0] hBack;
        logic [busWidth-1:0] vActive;
        logic [busWidth-1:0] vFront;
        logic [busWidth-1:0] vSync;
        logic [busWidth-1:0] vBack;
        logic                hSyncPol;
        logic                vSyncPol;
    } timingCfg_t;

    localparam timingCfg_t defaultCfg = '{
        hActive:  busWidth'(DEF_HACTIVE),
        hFront:   busWidth'(DEF_HFRONT),
        hSync:    busWidth'(DEF_HSYNC),
        hBack:    busWidth'(DEF_HBACK),
        vActive:  busWidth'(DEF_VACTIVE),
        vFront:   busWidth'(DEF_VFRONT),
        vSync:    busWidth'(DEF_VSYNC),
        vBack:    busWidth'(DEF_VBACK),
        hSyncPol: 1'b1,
        vSyncPol: 1'b1
    };

    timingCfg_t          shadowCfg;
    timingCfg_t          stageCfg;
    timingCfg_t          requestCfg;
    logic [busWidth-1:0] hPosReg;
    logic [busWidth-1:0] vPosReg;
    logic                hWrap;
    logic                vWrap;
    logic                hInActive;
    logic                hInSync;
    logic                vInActive;
    logic                vInSync;
    logic                applyNow;
    logic                nextHPol;
    logic                nextVPol;

    assign requestCfg = '{
        hActive:  vt.hActive,
        hFront:   vt.hFront,
        hSync:    vt.hSync,
        hBack:    vt.hBack,
        vActive:  vt.vActive,
        vFront:   vt.vFront,
        vSync:    vt.vSync,
        vBack:    vt.vBack,
        hSyncPol: vt.hSyncPol,
        vSyncPol: vt.vSyncPol
    };

    timing_axis #(.busWidth(busWidth)) hAxis (
        .clock    (clock),
        .reset    (reset),
        .advance  (vt.enable),
        .actLen   (shadowCfg.hActive),
        .frontLen (shadowCfg.hFront),
        .syncLen  (shadowCfg.hSync),
        .backLen  (shadowCfg.hBack),
        .pos      (hPosReg),
        .inActive (hInActive),
        .inSync   (hInSync),
        .wrap     (hWrap)
    );

    timing_axis #(.busWidth(busWidth)) vAxis (
        .clock    (clock),
        .reset    (reset),
        .advance  (hWrap),
        .actLen   (shadowCfg.vActive),
        .frontLen (shadowCfg.vFront),
        .syncLen  (shadowCfg.vSync),
        .backLen  (shadowCfg.vBack),
        .pos      (vPosReg),
        .inActive (vInActive),
        .inSync   (vInSync),
        .wrap     (vWrap)
    );

    assign vt.hPos = hPosReg;
    assign vt.vPos = vPosReg;

    // vWrap only fires on an enabled horizontal wrap, i.e. the edge into (0,0).
    assign applyNow = vWrap && vt.cfgPending;
    assign nextHPol = applyNow ? stageCfg.hSyncPol : shadowCfg.hSyncPol;
    assign nextVPol = applyNow ? stageCfg.vSyncPol : shadowCfg.vSyncPol;

    // Mode request staging and frame-boundary hand-over to the shadow set.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: staging is a handful of flops, not a memory, so it is reset like
        // any other state; reset thereby also discards an unapplied request.
        if (reset) begin
            shadowCfg     <= defaultCfg;
            stageCfg      <= defaultCfg;
            vt.cfgPending <= 1'b0;
        end else begin
            if (applyNow) begin
                shadowCfg     <= stageCfg;
                vt.cfgPending <= 1'b0;
            end
            // A request on the apply edge itself is kept for the following frame.
            if (vt.cfgUpdate) begin
                stageCfg      <= requestCfg;
                vt.cfgPending <= 1'b1;
            end
        end
    end

    // Raster outputs, registered on the same edge that loads hPos/vPos.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vt.deOut      <= 1'b0;
            vt.hSyncOut   <= 1'b0;
            vt.vSyncOut   <= 1'b0;
            vt.lineStart  <= 1'b0;
            vt.frameStart <= 1'b0;
        end else begin
            vt.deOut      <= vt.enable && hInActive && vInActive;
            vt.hSyncOut   <= (vt.enable && hInSync) ? nextHPol : !nextHPol;
            vt.vSyncOut   <= (vt.enable && vInSync) ? nextVPol : !nextVPol;
            vt.lineStart  <= hWrap;
            vt.frameStart <= vWrap;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a small mode (h 4/1/2/1, v 3/1/1/1):
// a table of raster positions, hand sequences for mode change, polarity,
// freeze and reset, then random traffic against a position/mode model.
module tb_video_timing_gen;

    localparam int BW = 12;

    typedef struct {
        int hA, hF, hS, hB;
        int vA, vF, vS, vB;
        bit hP, vP;
    } modeCfg_t;

    typedef struct {
        int n;
        int h;
        int v;
        bit de, hs, vs, ls, fs;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    video_timing_gen_if #(.busWidth(BW)) vt();

    video_timing_gen #(
        .busWidth(BW),
        .DEF_HACTIVE(4), .DEF_HFRONT(1), .DEF_HSYNC(2), .DEF_HBACK(1),
        .DEF_VACTIVE(3), .DEF_VFRONT(1), .DEF_VSYNC(1), .DEF_VBACK(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .vt    (vt)
    );

    int checkCount = 0;
    int passCount  = 0;

    modeCfg_t smallCfg;
    modeCfg_t mCur;
    modeCfg_t mStage;
    int       mh;
    int       mv;
    bit       mRun;
    bit       mPend;
    vec_t     vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    endtask

    function automatic int len1(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic int hTotal(input modeCfg_t c);
        return len1(c.hA) + len1(c.hF) + len1(c.hS) + len1(c.hB);
    endfunction

    function automatic int vTotal(input modeCfg_t c);
        return len1(c.vA) + len1(c.vF) + len1(c.vS) + len1(c.vB);
    endfunction

    function automatic modeCfg_t mkCfg(input int hA, hF, hS, hB, vA, vF, vS, vB,
                                       input bit hP, vP);
        modeCfg_t c;
        c.hA = hA; c.hF = hF; c.hS = hS; c.hB = hB;
        c.vA = vA; c.vF = vF; c.vS = vS; c.vB = vB;
        c.hP = hP; c.vP = vP;
        return c;
    endfunction

    function automatic modeCfg_t randCfg();
        return mkCfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 5), $urandom_range(0, 5),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    task automatic driveCfg(input modeCfg_t c);
        vt.hActive  = BW'(c.hA);
        vt.hFront   = BW'(c.hF);
        vt.hSync    = BW'(c.hS);
        vt.hBack    = BW'(c.hB);
        vt.vActive  = BW'(c.vA);
        vt.vFront   = BW'(c.vF);
        vt.vSync    = BW'(c.vS);
        vt.vBack    = BW'(c.vB);
        vt.hSyncPol = c.hP;
        vt.vSyncPol = c.vP;
    endtask

    task automatic modelReset();
        mh = 0; mv = 0; mRun = 0; mPend = 0;
        mCur = smallCfg; mStage = smallCfg;
    endtask

    // Raster position advances modulo the current totals; a staged mode takes
    // over when the position returns to (0,0).
    task automatic modelStep(input bit en, input bit upd, input modeCfg_t c);
        if (en) begin
            mh++;
            if (mh == hTotal(mCur)) begin
                mh = 0;
                mv++;
                if (mv == vTotal(mCur)) begin
                    mv = 0;
                    if (mPend) begin
                        mCur  = mStage;
                        mPend = 0;
                    end
                end
            end
        end
        if (upd) begin
            mStage = c;
            mPend  = 1;
        end
        mRun = en;
    endtask

    task automatic checkModel();
        int hA, hSyncStart, hSyncEnd, vA, vSyncStart, vSyncEnd;
        bit expDe, expHs, expVs, expLs, expFs;
        hA         = len1(mCur.hA);
        hSyncStart = hA + len1(mCur.hF);
        hSyncEnd   = hSyncStart + len1(mCur.hS);
        vA         = len1(mCur.vA);
        vSyncStart = vA + len1(mCur.vF);
        vSyncEnd   = vSyncStart + len1(mCur.vS);
        expDe = mRun && (mh < hA) && (mv < vA);
        expHs = (mRun && mh >= hSyncStart && mh < hSyncEnd) ? mCur.hP : !mCur.hP;
        expVs = (mRun && mv >= vSyncStart && mv < vSyncEnd) ? mCur.vP : !mCur.vP;
        expLs = mRun && (mh == 0);
        expFs = expLs && (mv == 0);
        check("model hPos", int'(vt.hPos), mh);
        check("model vPos", int'(vt.vPos), mv);
        check("model deOut", int'(vt.deOut), int'(expDe));
        check("model hSyncOut", int'(vt.hSyncOut), int'(expHs));
        check("model vSyncOut", int'(vt.vSyncOut), int'(expVs));
        check("model lineStart", int'(vt.lineStart), int'(expLs));
        check("model frameStart", int'(vt.frameStart), int'(expFs));
        check("model cfgPending", int'(vt.cfgPending), int'(mPend));
    endtask

    // One pixel clock: inputs are set at the falling edge, outputs compared at the next one.
    task automatic tick(input bit en, input bit upd, input modeCfg_t c);
        vt.enable    = en;
        vt.cfgUpdate = upd;
        driveCfg(c);
        modelStep(en, upd, c);
        @(posedge clock);
        @(negedge clock);
        vt.cfgUpdate = 1'b0;
        checkModel();
    endtask

    task automatic runUntil(input bit wantFrame, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 1000; i++) begin
            tick(1'b1, 1'b0, smallCfg);
            if (wantFrame ? vt.frameStart : vt.lineStart) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " hPos"}, int'(vt.hPos), 0);
        check({tag, " vPos"}, int'(vt.vPos), 0);
        check({tag, " deOut"}, int'(vt.deOut), 0);
        check({tag, " hSyncOut"}, int'(vt.hSyncOut), 0);
        check({tag, " vSyncOut"}, int'(vt.vSyncOut), 0);
        check({tag, " lineStart"}, int'(vt.lineStart), 0);
        check({tag, " frameStart"}, int'(vt.frameStart), 0);
        check({tag, " cfgPending"}, int'(vt.cfgPending), 0);
    endtask

    // Asynchronous reset between clock edges, with a mode request outstanding.
    task automatic midReset(input string tag);
        tick(1'b1, 1'b1, randCfg());
        check({tag, " pending before reset"}, int'(vt.cfgPending), 1);
        #2 reset = 1'b1;
        #1 checkResetOutputs(tag);
        modelReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int c;
        int c2;
        int lastLs;
        int vsCount;
        int vsBad;
        int fsEarly;
        bit gotFs;
        modeCfg_t wideCfg;
        modeCfg_t polLowCfg;
        modeCfg_t front0Cfg;
        modeCfg_t rc;
        bit en;
        bit upd;

        smallCfg  = mkCfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        wideCfg   = mkCfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        polLowCfg = mkCfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1);
        front0Cfg = mkCfg(4, 0, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);

        //            n   h  v  de hs vs ls fs
        vecs[0]  = '{ 1,  1, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{ 4,  4, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{ 5,  5, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{ 6,  6, 0, 0, 1, 0, 0, 0};
        vecs[4]  = '{ 7,  7, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{ 8,  0, 1, 1, 0, 0, 1, 0};
        vecs[6]  = '{11,  3, 1, 1, 0, 0, 0, 0};
        vecs[7]  = '{24,  0, 3, 0, 0, 0, 1, 0};
        vecs[8]  = '{32,  0, 4, 0, 0, 1, 1, 0};
        vecs[9]  = '{39,  7, 4, 0, 0, 1, 0, 0};
        vecs[10] = '{40,  0, 5, 0, 0, 0, 1, 0};
        vecs[11] = '{48,  0, 0, 1, 0, 0, 1, 1};

        reset        = 1'b1;
        vt.enable    = 1'b0;
        vt.cfgUpdate = 1'b0;
        driveCfg(smallCfg);
        #1 checkResetOutputs("power-on");
        modelReset();
        @(negedge clock);
        reset = 1'b0;

        // First frame from reset release, compared against the position table.
        n = 0;
        for (int k = 0; k < 12; k++) begin
            while (n < vecs[k].n) begin
                tick(1'b1, 1'b0, smallCfg);
                n++;
            end
            check($sformatf("vec%0d hPos", k), int'(vt.hPos), vecs[k].h);
            check($sformatf("vec%0d vPos", k), int'(vt.vPos), vecs[k].v);
            check($sformatf("vec%0d deOut", k), int'(vt.deOut), int'(vecs[k].de));
            check($sformatf("vec%0d hSyncOut", k), int'(vt.hSyncOut), int'(vecs[k].hs));
            check($sformatf("vec%0d vSyncOut", k), int'(vt.vSyncOut), int'(vecs[k].vs));
            check($sformatf("vec%0d lineStart", k), int'(vt.lineStart), int'(vecs[k].ls));
            check($sformatf("vec%0d frameStart", k), int'(vt.frameStart), int'(vecs[k].fs));
        end

        // One full frame: line period 8, vSync exactly on line 4, frame period 48.
        lastLs = 0; vsCount = 0; vsBad = 0; fsEarly = 0;
        for (int i = 1; i <= 48; i++) begin
            tick(1'b1, 1'b0, smallCfg);
            if (vt.lineStart) begin
                check("lineStart period", i - lastLs, 8);
                lastLs = i;
            end
            if (vt.vSyncOut) begin
                vsCount++;
                if (vt.vPos != BW'(4)) vsBad++;
            end
            if (vt.frameStart && i != 48) fsEarly++;
        end
        check("vSync cycles per frame", vsCount, 8);
        check("vSync outside line 4", vsBad, 0);
        check("frameStart before 48 cycles", fsEarly, 0);
        check("frameStart at 48 cycles", int'(vt.frameStart), 1);

        // Mode change mid-frame: current frame keeps 48 cycles, next uses hTotal 10.
        c = -1; gotFs = 0;
        for (int i = 1; i <= 200 && !gotFs; i++) begin
            tick(1'b1, i == 10, wideCfg);
            if (i == 11) check("cfgPending after update", int'(vt.cfgPending), 1);
            if (vt.frameStart) begin
                gotFs = 1;
                c = i;
            end
        end
        check("frame length across update", c, 48);
        check("cfgPending at new frameStart", int'(vt.cfgPending), 0);
        runUntil(1'b0, c);
        check("lineStart period after update", c, 10);
        runUntil(1'b1, c2);
        check("frame period after update", c + c2, 60);

        // Active-low hSync: inverted only in the sync window, deOut unaffected.
        tick(1'b1, 1'b1, polLowCfg);
        runUntil(1'b1, c);
        check("polarity frame reached", int'(c > 0), 1);
        for (int j = 0; j < 8; j++) begin
            check("pol hPos", int'(vt.hPos), j);
            check("pol hSyncOut", int'(vt.hSyncOut), (j == 5 || j == 6) ? 0 : 1);
            check("pol deOut", int'(vt.deOut), (j < 4) ? 1 : 0);
            tick(1'b1, 1'b0, smallCfg);
        end

        // Freeze at (2,1) for five cycles, then resume at hPos 3.
        for (int i = 0; i < 100; i++) begin
            if (vt.hPos == BW'(2) && vt.vPos == BW'(1)) break;
            tick(1'b1, 1'b0, smallCfg);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, smallCfg);
            check("frozen hPos", int'(vt.hPos), 2);
            check("frozen vPos", int'(vt.vPos), 1);
            check("frozen deOut", int'(vt.deOut), 0);
        end
        tick(1'b1, 1'b0, smallCfg);
        check("resume hPos", int'(vt.hPos), 3);
        check("resume deOut", int'(vt.deOut), 1);

        // Zero front porch counts as one pixel: hTotal stays 8.
        tick(1'b1, 1'b1, front0Cfg);
        runUntil(1'b1, c);
        check("front0 frame reached", int'(c > 0), 1);
        runUntil(1'b0, c);
        check("front0 line period", c, 8);

        // Asynchronous reset in the middle of a line.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, smallCfg);
        midReset("mid-line reset");

        // Random run/freeze and mode requests against the model.
        for (int i = 0; i < 2500; i++) begin
            rc  = randCfg();
            en  = ($urandom_range(0, 9) != 0);
            upd = ($urandom_range(0, 39) == 0);
            if (i == 1200) midReset("random reset");
            tick(en, upd, rc);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
